// File: rtl/csa_resolve_if.sv
// Valid/ready handshake bundle for the carry-save resolver: operand side and result side.
// The master modport belongs to the producer/consumer and the slave modport to the resolver.
interface csa_resolve_if #(
    parameter int WIDE = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [WIDE-1:0] ps;
    logic [WIDE-1:0] pc;
    logic            out_valid;
    logic            out_ready;
    logic [WIDE+1:0] sum;

    modport master (
        output in_valid, ps, pc, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, ps, pc, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/csa_resolve.sv
// Converts a carry-save pair (ps, pc) into binary ps + 2*pc.
// Resolution is digit-serial: CHUNK bits per cycle through one shared small adder.
module csa_resolve #(
    parameter int WIDE  = 8,
    parameter int CHUNK = 4
) (
    input logic         clk,
    input logic         rst,
    csa_resolve_if.slave bus
);
    localparam int EXTW = WIDE + 2;
    localparam int NCH  = (EXTW + CHUNK - 1) / CHUNK;
    localparam int PADW = NCH * CHUNK;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [PADW-1:0]   opA_q, opA_d;
    logic [PADW-1:0]   opB_q, opB_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [EXTW-1:0]   result_q, result_d;
    logic [CHUNK-1:0]  chunkA;
    logic [CHUNK-1:0]  chunkB;
    logic [CHUNK:0]    chunkSum;

    // One chunk of each padded operand plus the carry from the previous chunk.
    assign chunkA   = opA_q[cnt_q*CHUNK +: CHUNK];
    assign chunkB   = opB_q[cnt_q*CHUNK +: CHUNK];
    assign chunkSum = {1'b0, chunkA} + {1'b0, chunkB} + {{CHUNK{1'b0}}, carry_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opA_d   = PADW'(bus.ps);
                    opB_d   = PADW'({bus.pc, 1'b0});
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Only the bits of the current chunk that fall inside the result are written.
                for (int i = 0; i < EXTW; i++) begin
                    if ((i / CHUNK) == int'(cnt_q)) begin
                        result_d[i] = chunkSum[i % CHUNK];
                    end
                end
                carry_d = chunkSum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NCH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = result_q;
endmodule
